// File: rtl/pipeline_if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Bubble instruction, reset PC, IF state encoding and stall-vector bit positions.
package pipeline_if_pkg;

    localparam logic [31:0] NopInst = 32'h0000_0013;
    localparam logic [31:0] ResetPC = 32'h0000_0000;

    localparam int StallIf = 0;
    localparam int StallId = 1;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

endpackage

// File: rtl/pipeline_if_if.sv
// Instruction-memory request/acknowledge bus.
// Master holds req with a stable addr until a one-cycle ack returns rdata.
interface pipeline_if_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/pipeline_if_fetch_ctrl.sv
// Fetch FSM with PC, redirect target and stall buffer.
// Decides when an instruction is delivered towards the IF/ID register.
module pipeline_if_fetch_ctrl
    import pipeline_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPC
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_if_if.master mem,
    input  logic          branch_en_i,
    input  logic [31:0]   branch_target_i,
    input  logic          stall_id_i,
    output logic          stall_req_o,
    output logic          deliver_o,
    output logic [31:0]   dlv_inst_o,
    output logic [31:0]   dlv_pc_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] buf_q, buf_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] tgt;
    logic        ack;

    assign tgt = {branch_target_i[31:2], 2'b00};
    assign ack = mem.ack;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IF_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a redirect always returns to FETCH unless a request is still open.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IF_IDLE:  state_d = IF_FETCH;
            IF_FETCH: begin
                if (branch_en_i)          state_d = ack ? IF_FETCH : IF_DRAIN;
                else if (ack && stall_id_i) state_d = IF_HOLD;
            end
            IF_HOLD:  if (branch_en_i || !stall_id_i) state_d = IF_FETCH;
            IF_DRAIN: if (ack) state_d = IF_FETCH;
            default:  state_d = IF_IDLE;
        endcase
    end

    // PC, pending redirect and stall-buffer next values.
    always_comb begin
        pc_d      = pc_q;
        redir_d   = redir_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        unique case (state_q)
            IF_IDLE:  if (branch_en_i) pc_d = tgt;
            IF_FETCH: begin
                if (branch_en_i) begin
                    if (ack) pc_d    = tgt;
                    else     redir_d = tgt;
                end else if (ack) begin
                    if (stall_id_i) begin
                        buf_d     = mem.rdata;
                        buf_vld_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            IF_HOLD: begin
                if (branch_en_i) begin
                    pc_d      = tgt;
                    buf_vld_d = 1'b0;
                end else if (!stall_id_i) begin
                    pc_d      = pc_q + 32'd4;
                    buf_vld_d = 1'b0;
                end
            end
            IF_DRAIN: begin
                if (branch_en_i) redir_d = tgt;
                if (ack)         pc_d    = branch_en_i ? tgt : redir_q;
            end
            default: ;
        endcase
    end

    // PC, redirect and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            redir_q   <= RESET_PC;
            buf_q     <= NopInst;
            buf_vld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
        end
    end

    // Bus request, stall request and delivery outputs.
    always_comb begin
        mem.req     = (state_q == IF_FETCH) || (state_q == IF_DRAIN);
        mem.addr    = {pc_q[31:2], 2'b00};
        stall_req_o = (state_q == IF_IDLE)
                   || (state_q == IF_DRAIN)
                   || ((state_q == IF_FETCH) && !ack);
        deliver_o   = !branch_en_i && !stall_id_i
                   && (((state_q == IF_FETCH) && ack)
                    || ((state_q == IF_HOLD) && buf_vld_q));
        dlv_inst_o  = (state_q == IF_HOLD) ? buf_q : mem.rdata;
        dlv_pc_o    = pc_q;
    end

endmodule

// File: rtl/pipeline_if.sv
// Instruction-fetch stage top: fetch controller plus IF/ID register.
// Flush beats ID stall, which beats delivery; anything else inserts a bubble.
module pipeline_if
    import pipeline_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPC,
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_if_if.master mem,
    input  logic          branch_en_i,
    input  logic [31:0]   branch_target_i,
    input  logic [4:0]    stall_i,
    output logic          stall_req_o,
    output logic [31:0]   inst_o,
    output logic [31:0]   pc_o
);

    logic        deliver;
    logic [31:0] dlv_inst;
    logic [31:0] dlv_pc;
    logic        unused_bits;

    assign unused_bits = ^{stall_i[4:2], stall_i[StallIf]};

    pipeline_if_fetch_ctrl #(
        .RESET_PC (RESET_PC)
    ) u_fetch_ctrl (
        .clk             (clk),
        .rst             (rst),
        .mem             (mem),
        .branch_en_i     (branch_en_i),
        .branch_target_i (branch_target_i),
        .stall_id_i      (stall_i[StallId]),
        .stall_req_o     (stall_req_o),
        .deliver_o       (deliver),
        .dlv_inst_o      (dlv_inst),
        .dlv_pc_o        (dlv_pc)
    );

    // IF/ID pipeline register with flush/stall/deliver priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o <= NOP_INST;
            pc_o   <= RESET_PC;
        end else if (branch_en_i) begin
            inst_o <= NOP_INST;
        end else if (stall_i[StallId]) begin
            inst_o <= inst_o;
            pc_o   <= pc_o;
        end else if (deliver) begin
            inst_o <= dlv_inst;
            pc_o   <= dlv_pc;
        end else begin
            inst_o <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for the instruction-fetch stage.
// Hand-computed expectations checked with immediate assertions.
module tb_pipeline_if;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_en;
    logic [31:0] branch_tgt;
    logic [4:0]  stall;
    logic        stall_req;
    logic [31:0] inst;
    logic [31:0] pc;
    int          errors = 0;
    int          checks = 0;

    pipeline_if_if mem_bus ();

    pipeline_if dut (
        .clk             (clk),
        .rst             (rst),
        .mem             (mem_bus),
        .branch_en_i     (branch_en),
        .branch_target_i (branch_tgt),
        .stall_i         (stall),
        .stall_req_o     (stall_req),
        .inst_o          (inst),
        .pc_o            (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic [31:0] d,
                         input logic s1, input logic br,
                         input logic [31:0] t);
        mem_bus.ack   = a;
        mem_bus.rdata = d;
        stall         = {3'b000, s1, 1'b0};
        branch_en     = br;
        branch_tgt    = t;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_inst", inst, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, mem_bus.req}, 32'd0);

        rst = 1'b0;
        #1;
        chk("idle_req", {31'd0, mem_bus.req}, 32'd0);
        chk("idle_sreq", {31'd0, stall_req}, 32'd1);
        tick();
        chk("idle_inst", inst, NOP);
        chk("f0_req", {31'd0, mem_bus.req}, 32'd1);
        chk("f0_addr", mem_bus.addr, 32'h0);

        drive(1'b1, 32'h00A00093, 1'b0, 1'b0, 32'h0);
        chk("f0_sreq", {31'd0, stall_req}, 32'd0);
        tick();
        chk("d0_inst", inst, 32'h00A00093);
        chk("d0_pc", pc, 32'h0);
        chk("f4_addr", mem_bus.addr, 32'h4);

        drive(1'b1, 32'h00100113, 1'b0, 1'b0, 32'h0);
        tick();
        chk("d4_inst", inst, 32'h00100113);
        chk("d4_pc", pc, 32'h4);
        chk("f8_addr", mem_bus.addr, 32'h8);

        drive(1'b1, 32'h00208193, 1'b1, 1'b0, 32'h0);
        chk("ack_stall_sreq", {31'd0, stall_req}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("hold_req", {31'd0, mem_bus.req}, 32'd0);
        chk("hold_sreq", {31'd0, stall_req}, 32'd0);
        chk("hold_inst", inst, 32'h00100113);
        chk("hold_pc", pc, 32'h4);
        tick();
        chk("hold2_inst", inst, 32'h00100113);
        chk("hold2_pc", pc, 32'h4);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("rel_inst", inst, 32'h00208193);
        chk("rel_pc", pc, 32'h8);
        chk("fc_req", {31'd0, mem_bus.req}, 32'd1);
        chk("fc_addr", mem_bus.addr, 32'hC);

        for (int w = 0; w < 3; w++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("wait_addr", mem_bus.addr, 32'hC);
            chk("wait_sreq", {31'd0, stall_req}, 32'd1);
            tick();
            chk("wait_inst", inst, NOP);
        end
        drive(1'b1, 32'h00308213, 1'b0, 1'b0, 32'h0);
        chk("wait_ack_addr", mem_bus.addr, 32'hC);
        tick();
        chk("dc_inst", inst, 32'h00308213);
        chk("dc_pc", pc, 32'hC);
        chk("f10_addr", mem_bus.addr, 32'h10);

        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        tick();
        chk("br_inst", inst, NOP);
        chk("br_pc", pc, 32'hC);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("drain_req", {31'd0, mem_bus.req}, 32'd1);
        chk("drain_addr", mem_bus.addr, 32'h10);
        chk("drain_sreq", {31'd0, stall_req}, 32'd1);
        tick();
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        chk("drain_ack_sreq", {31'd0, stall_req}, 32'd1);
        tick();
        chk("drain_drop", inst, NOP);
        chk("f100_addr", mem_bus.addr, 32'h100);

        drive(1'b1, 32'h00400293, 1'b0, 1'b0, 32'h0);
        tick();
        chk("d100_inst", inst, 32'h00400293);
        chk("d100_pc", pc, 32'h100);
        chk("f104_addr", mem_bus.addr, 32'h104);

        drive(1'b1, 32'h11111111, 1'b1, 1'b1, 32'h103);
        tick();
        chk("flush_inst", inst, NOP);
        chk("flush_pc", pc, 32'h100);
        chk("flush_addr", mem_bus.addr, 32'h100);
        chk("flush_req", {31'd0, mem_bus.req}, 32'd1);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_req", {31'd0, mem_bus.req}, 32'd0);
        chk("mrst_inst", inst, NOP);
        chk("mrst_pc", pc, 32'h0);
        tick();
        chk("mrst_addr", mem_bus.addr, 32'h0);

        drive(1'b1, 32'h22222222, 1'b0, 1'b1, 32'hFFFF_FFFE);
        tick();
        chk("wrap_fetch", mem_bus.addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_inst", inst, 32'h33333333);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_addr", mem_bus.addr, 32'h0);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
